// File: rtl/apb_value_bank_pkg.sv
// Shared register map, control/status bit positions and state encoding
// for the APB value bank.
package apb_value_bank_pkg;

    localparam logic [7:0] OFS_CTRL       = 8'h00;
    localparam logic [7:0] OFS_STATUS     = 8'h04;
    localparam logic [7:0] OFS_COMMIT_CNT = 8'h08;
    localparam logic [7:0] OFS_CH_BASE    = 8'h10;

    localparam int CTRL_AUTO_BIT   = 0;
    localparam int CTRL_COMMIT_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;

    localparam int STATUS_STB_BIT   = 0;
    localparam int STATUS_OVR_BIT   = 1;
    localparam int STATUS_CLAMP_BIT = 2;

    localparam int CNT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_STATUS,
        REG_CNT,
        REG_CH
    } reg_sel_e;

endpackage

// File: rtl/apb3_reg_decode.sv
// APB3 address decode and combinational read mux for the value bank.
// Only PADDR[7:0] participates; unaligned or out-of-range offsets are unmapped.
module apb3_reg_decode
    import apb_value_bank_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int VAL_WIDTH  = 20,
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0]       paddr,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        ctrlAuto,
    input  logic [2:0]                  statusBits,
    input  logic [CNT_WIDTH-1:0]        commitCnt,
    input  logic [NUM_CH*VAL_WIDTH-1:0] shadowFlat,
    output logic                        access,
    output logic                        mapped,
    output reg_sel_e                    regSel,
    output logic [3:0]                  chIdx,
    output logic [31:0]                 prdata
);

    logic [7:0]           offset;
    logic [7:0]           chOffset;
    logic [VAL_WIDTH-1:0] chVal;
    logic                 unusedAddrBits;

    assign access         = psel & penable;
    assign offset         = paddr[7:0];
    assign chOffset       = offset - OFS_CH_BASE;
    assign chIdx          = chOffset[5:2];
    assign unusedAddrBits = ^{paddr[ADDR_WIDTH-1:8], chOffset[1:0]};

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case leaves it holding its old value (a latch).
    always_comb begin
        regSel = REG_CTRL;
        mapped = 1'b0;
        if (offset[1:0] == 2'b00) begin
            if (offset == OFS_CTRL) begin
                regSel = REG_CTRL;
                mapped = 1'b1;
            end else if (offset == OFS_STATUS) begin
                regSel = REG_STATUS;
                mapped = 1'b1;
            end else if (offset == OFS_COMMIT_CNT) begin
                regSel = REG_CNT;
                mapped = 1'b1;
            end else if (offset >= OFS_CH_BASE && chOffset[7:6] == 2'b00
                         && {1'b0, chIdx} < 5'(NUM_CH)) begin
                regSel = REG_CH;
                mapped = 1'b1;
            end
        end
    end

    always_comb begin
        chVal = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chIdx == 4'(i)) chVal = shadowFlat[i*VAL_WIDTH +: VAL_WIDTH];
        end

        // Read data is driven only during a mapped access cycle.
        prdata = '0;
        if (access && mapped) begin
            case (regSel)
                REG_CTRL:   prdata[CTRL_AUTO_BIT] = ctrlAuto;
                REG_STATUS: prdata[2:0] = statusBits;
                REG_CNT:    prdata[CNT_WIDTH-1:0] = commitCnt;
                REG_CH:     prdata = 32'(chVal);
                default:    prdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/apb_value_bank.sv
// APB3 bank of clamped shadow values committed as a set to val_flat, with a
// strobe/acknowledge handshake, overrun and clamp sticky flags and a commit counter.
module apb_value_bank
    import apb_value_bank_pkg::*;
#(
    parameter int          NUM_CH     = 3,
    parameter int          VAL_WIDTH  = 20,
    parameter logic [31:0] MAX_VAL    = 32'((64'd1 << VAL_WIDTH) - 64'd1),
    parameter int          ADDR_WIDTH = 16
) (
    input  logic                        io_systemClk,
    input  logic                        io_asyncReset,
    input  logic [ADDR_WIDTH-1:0]       PADDR,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [31:0]                 PWDATA,
    output logic [31:0]                 PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERROR,
    output logic [NUM_CH*VAL_WIDTH-1:0] val_flat,
    output logic                        val_stb,
    input  logic                        val_ack
);

    bank_state_e state, stateNext;

    logic [VAL_WIDTH-1:0]        shadow     [NUM_CH];
    logic [VAL_WIDTH-1:0]        shadowNext [NUM_CH];
    logic [NUM_CH*VAL_WIDTH-1:0] shadowFlat;
    logic [NUM_CH*VAL_WIDTH-1:0] commitFlat;

    logic                 ctrlAuto;
    logic                 ovr;
    logic                 clamp;
    logic [CNT_WIDTH-1:0] commitCnt;
    logic [2:0]           statusBits;

    logic                 access;
    logic                 mapped;
    reg_sel_e             regSel;
    logic [3:0]           chIdx;

    logic                 wrEn;
    logic                 ctrlWr;
    logic                 statusWr;
    logic                 chWr;
    logic                 overMax;
    logic                 commit;
    logic                 clear;
    logic                 ovrSet;
    logic                 clampSet;
    logic [VAL_WIDTH-1:0] clampedVal;

    apb3_reg_decode #(
        .NUM_CH     (NUM_CH),
        .VAL_WIDTH  (VAL_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .paddr      (PADDR),
        .psel       (PSEL),
        .penable    (PENABLE),
        .ctrlAuto   (ctrlAuto),
        .statusBits (statusBits),
        .commitCnt  (commitCnt),
        .shadowFlat (shadowFlat),
        .access     (access),
        .mapped     (mapped),
        .regSel     (regSel),
        .chIdx      (chIdx),
        .prdata     (PRDATA)
    );

    assign PREADY     = 1'b1;
    assign PSLVERROR  = access & ~mapped;
    assign statusBits = {clamp, ovr, val_stb};

    assign wrEn     = access & mapped & PWRITE;
    assign ctrlWr   = wrEn && (regSel == REG_CTRL);
    assign statusWr = wrEn && (regSel == REG_STATUS);
    assign chWr     = wrEn && (regSel == REG_CH);

    assign overMax    = PWDATA > MAX_VAL;
    assign clampedVal = overMax ? MAX_VAL[VAL_WIDTH-1:0] : PWDATA[VAL_WIDTH-1:0];

    // AUTO commits on the last channel, so the committed set must include
    // the value being written in that same cycle.
    assign commit   = (ctrlWr & PWDATA[CTRL_COMMIT_BIT])
                    | (ctrlAuto & chWr & (chIdx == 4'(NUM_CH - 1)));
    assign clear    = ctrlWr & PWDATA[CTRL_CLEAR_BIT];
    assign ovrSet   = commit & (state == ST_PENDING) & ~val_ack;
    assign clampSet = chWr & overMax;

    always_comb begin
        shadowFlat = '0;
        commitFlat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            shadowNext[i] = shadow[i];
            if (chWr && chIdx == 4'(i)) shadowNext[i] = clampedVal;
            shadowFlat[i*VAL_WIDTH +: VAL_WIDTH] = shadow[i];
            commitFlat[i*VAL_WIDTH +: VAL_WIDTH] = shadowNext[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the shadows are a handful of flops rather than a RAM, so they
    // take part in the asynchronous reset like every other register.
    always_ff @(posedge io_systemClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
            val_flat  <= '0;
            commitCnt <= '0;
            ctrlAuto  <= 1'b0;
            ovr       <= 1'b0;
            clamp     <= 1'b0;
        end else begin
            // CLEAR only zeroes the shadows; a simultaneous commit already
            // captured their pre-clear contents via commitFlat.
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= clear ? '0 : shadowNext[i];
            if (commit) begin
                val_flat  <= commitFlat;
                commitCnt <= commitCnt + 16'd1;
            end
            if (ctrlWr) ctrlAuto <= PWDATA[CTRL_AUTO_BIT];
            ovr   <= ovrSet   | (ovr   & ~(statusWr & PWDATA[STATUS_OVR_BIT]));
            clamp <= clampSet | (clamp & ~(statusWr & PWDATA[STATUS_CLAMP_BIT]));
        end
    end

    always_ff @(posedge io_systemClk or posedge io_asyncReset) begin
        if (io_asyncReset) state <= ST_IDLE;
        else               state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        val_stb   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit) stateNext = ST_PENDING;
            end
            ST_PENDING: begin
                val_stb = 1'b1;
                if (!commit && val_ack) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_value_bank.sv
// Randomized plus directed bench for apb_value_bank: a full-range instance and a
// MAX_VAL=999 instance share one APB bus and are checked against a register-level model.
module tb_apb_value_bank;

    localparam int NCH = 3;
    localparam int VW  = 20;
    localparam int FW  = NCH * VW;

    logic periCLK = 1'b0;
    logic asyncReset;
    logic [15:0] paddr;
    logic psel, penable, pwrite, valAck;
    logic [31:0] pwdata;

    logic [1:0][31:0] prdata;
    logic [1:0]       pready, pslverr, valStb;
    logic [1:0][FW-1:0] valFlat;

    int nCmp  = 0;
    int nFail = 0;

    // Reference model: one register image per instance.
    int unsigned mMax [2] = '{32'h000F_FFFF, 32'd999};
    int unsigned mShadow [2][NCH];
    int unsigned mFlat   [2][NCH];
    bit          mAuto [2], mOvr [2], mClamp [2], mPend [2];
    int unsigned mCnt  [2];

    always #5 periCLK = ~periCLK;

    apb_value_bank #(.NUM_CH(NCH), .VAL_WIDTH(VW), .ADDR_WIDTH(16)) dutFull (
        .io_systemClk (periCLK),    .io_asyncReset (asyncReset),
        .PADDR        (paddr),      .PSEL          (psel),
        .PENABLE      (penable),    .PWRITE        (pwrite),
        .PWDATA       (pwdata),     .PRDATA        (prdata[0]),
        .PREADY       (pready[0]),  .PSLVERROR     (pslverr[0]),
        .val_flat     (valFlat[0]), .val_stb       (valStb[0]),
        .val_ack      (valAck)
    );

    apb_value_bank #(.NUM_CH(NCH), .VAL_WIDTH(VW), .MAX_VAL(32'd999), .ADDR_WIDTH(16)) dutClamp (
        .io_systemClk (periCLK),    .io_asyncReset (asyncReset),
        .PADDR        (paddr),      .PSEL          (psel),
        .PENABLE      (penable),    .PWRITE        (pwrite),
        .PWDATA       (pwdata),     .PRDATA        (prdata[1]),
        .PREADY       (pready[1]),  .PSLVERROR     (pslverr[1]),
        .val_flat     (valFlat[1]), .val_stb       (valStb[1]),
        .val_ack      (valAck)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCH; c++) begin
                mShadow[i][c] = 0;
                mFlat[i][c]   = 0;
            end
            mAuto[i] = 0; mOvr[i] = 0; mClamp[i] = 0; mPend[i] = 0; mCnt[i] = 0;
        end
    endtask

    function automatic logic [FW-1:0] expFlat(input int i);
        logic [FW-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*VW +: VW] = VW'(mFlat[i][c]);
        return r;
    endfunction

    // One clock edge of the register image: returns the read data/error seen
    // during the cycle, then applies its effects.
    task automatic modelStep(input int i, input bit acc, input bit wr, input logic [15:0] addr,
                             input logic [31:0] data, input bit ack,
                             output logic [31:0] rd, output bit err);
        int a, ch;
        bit isCtrl, isStat, isCnt, isCh, doCommit, clampNow;
        a        = int'(addr[7:0]);
        ch       = (a - 16) / 4;
        isCtrl   = (a == 0);
        isStat   = (a == 4);
        isCnt    = (a == 8);
        isCh     = (a >= 16) && (a % 4 == 0) && (ch < NCH);
        err      = acc && !(isCtrl || isStat || isCnt || isCh);
        rd       = 0;
        doCommit = 0;
        clampNow = 0;
        if (acc && !err) begin
            if (isCtrl)      rd = {31'd0, mAuto[i]};
            else if (isStat) rd = {29'd0, mClamp[i], mOvr[i], mPend[i]};
            else if (isCnt)  rd = mCnt[i];
            else             rd = mShadow[i][ch];
        end
        if (acc && wr && !err) begin
            if (isCh) begin
                clampNow = data > mMax[i];
                mShadow[i][ch] = (clampNow ? mMax[i] : data) & ((32'd1 << VW) - 1);
                doCommit = mAuto[i] && (ch == NCH - 1);
            end
            if (isCtrl) doCommit = data[1];
            if (isStat) begin
                if (data[1]) mOvr[i] = 0;
                if (data[2]) mClamp[i] = 0;
            end
        end
        if (doCommit) begin
            for (int c = 0; c < NCH; c++) mFlat[i][c] = mShadow[i][c];
            mCnt[i] = (mCnt[i] + 1) % 65536;
            if (mPend[i] && !ack) mOvr[i] = 1;
            mPend[i] = 1;
        end else if (ack) begin
            mPend[i] = 0;
        end
        if (clampNow) mClamp[i] = 1;
        if (acc && wr && !err && isCtrl) begin
            if (data[2]) for (int c = 0; c < NCH; c++) mShadow[i][c] = 0;
            mAuto[i] = data[0];
        end
    endtask

    task automatic checkOutputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s val_flat[%0d]", tag, i), 64'(valFlat[i]), 64'(expFlat(i)));
            check($sformatf("%s val_stb[%0d]", tag, i), 64'(valStb[i]), 64'(mPend[i]));
        end
    endtask

    task automatic apbXfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                           input bit ack, output logic [1:0][31:0] rd, output logic [1:0] err);
        logic [31:0] expRd;
        bit          expErr;
        @(posedge periCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; valAck = 1'b0;
        @(posedge periCLK); #1;
        penable = 1'b1; valAck = ack;
        @(negedge periCLK);
        rd  = prdata;
        err = pslverr;
        for (int i = 0; i < 2; i++) begin
            modelStep(i, 1'b1, wr, addr, data, ack, expRd, expErr);
            check($sformatf("pslverr[%0d] @%h", i, addr), 64'(pslverr[i]), 64'(expErr));
            check($sformatf("pready[%0d]", i), 64'(pready[i]), 64'd1);
            if (!wr) check($sformatf("prdata[%0d] @%h", i, addr), 64'(prdata[i]), 64'(expRd));
        end
        @(posedge periCLK); #1;
        psel = 1'b0; penable = 1'b0; valAck = 1'b0;
        checkOutputs($sformatf("after %s %h", wr ? "wr" : "rd", addr));
    endtask

    task automatic ackCycle();
        logic [31:0] dRd;
        bit          dErr;
        @(posedge periCLK); #1;
        valAck = 1'b1;
        @(posedge periCLK);
        for (int i = 0; i < 2; i++) modelStep(i, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, dRd, dErr);
        #1 valAck = 1'b0;
        checkOutputs("ack");
    endtask

    task automatic pulseReset();
        @(negedge periCLK); asyncReset = 1'b1;
        @(negedge periCLK); asyncReset = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [1:0][31:0] rd;
        logic [1:0]       err;
        logic [15:0]      addrs [11];
        logic [15:0]      addr;
        logic [31:0]      data;
        logic [31:0]      dRd;
        bit               dErr;

        addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h0010, 16'h0014, 16'h0018,
                  16'h0018, 16'h001C, 16'h0040, 16'h000C, 16'hAB14};

        asyncReset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; valAck = 1'b0;
        modelReset();
        repeat (3) @(posedge periCLK);
        @(negedge periCLK);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset val_flat[%0d]", i), 64'(valFlat[i]), 64'd0);
            check($sformatf("reset val_stb[%0d]", i), 64'(valStb[i]), 64'd0);
            check($sformatf("reset prdata[%0d]", i), 64'(prdata[i]), 64'd0);
            check($sformatf("reset pslverr[%0d]", i), 64'(pslverr[i]), 64'd0);
        end
        asyncReset = 1'b0;
        apbXfer(1'b0, 16'h0000, 32'h0, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0004, 32'h0, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0008, 32'h0, 1'b0, rd, err);

        // Basic commit of three channel values.
        apbXfer(1'b1, 16'h0010, 32'd98,   1'b0, rd, err);
        apbXfer(1'b1, 16'h0014, 32'd72,   1'b0, rd, err);
        apbXfer(1'b1, 16'h0018, 32'd1500, 1'b0, rd, err);
        apbXfer(1'b1, 16'h0000, 32'h2,    1'b0, rd, err);
        check("commit ch0", 64'(valFlat[0][19:0]),  64'd98);
        check("commit ch1", 64'(valFlat[0][39:20]), 64'd72);
        check("commit ch2", 64'(valFlat[0][59:40]), 64'd1500);
        check("commit ch2 clamped", 64'(valFlat[1][59:40]), 64'd999);
        check("commit stb", 64'(valStb[0]), 64'd1);
        apbXfer(1'b0, 16'h0008, 32'h0, 1'b0, rd, err);
        check("commit cnt", 64'(rd[0]), 64'd1);
        ackCycle();

        // Clamp and W1C of CLAMP.
        apbXfer(1'b1, 16'h0018, 32'h12345, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0018, 32'h0, 1'b0, rd, err);
        check("clamp shadow", 64'(rd[1]), 64'd999);
        check("unclamped shadow", 64'(rd[0]), 64'h12345);
        apbXfer(1'b0, 16'h0004, 32'h0, 1'b0, rd, err);
        check("clamp status", 64'(rd[1]), 64'h4);
        apbXfer(1'b1, 16'h0004, 32'h4, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0004, 32'h0, 1'b0, rd, err);
        check("clamp w1c", 64'(rd[1]), 64'h0);

        // AUTO commits and overrun.
        apbXfer(1'b1, 16'h0000, 32'h1, 1'b0, rd, err);
        apbXfer(1'b1, 16'h0018, 32'd5, 1'b0, rd, err);
        apbXfer(1'b1, 16'h0018, 32'd5, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0004, 32'h0, 1'b0, rd, err);
        check("ovr status", 64'(rd[0]), 64'h3);
        ackCycle();
        check("ack drops stb", 64'(valStb[0]), 64'd0);

        // Commit coinciding with acknowledge.
        apbXfer(1'b1, 16'h0004, 32'h2, 1'b0, rd, err);
        apbXfer(1'b1, 16'h0018, 32'd7, 1'b0, rd, err);
        apbXfer(1'b1, 16'h0018, 32'd8, 1'b1, rd, err);
        check("ack+commit stb", 64'(valStb[0]), 64'd1);
        check("ack+commit value", 64'(valFlat[0][59:40]), 64'd8);
        apbXfer(1'b0, 16'h0004, 32'h0, 1'b0, rd, err);
        check("ack+commit no ovr", 64'(rd[0]), 64'h1);

        // Unmapped accesses.
        apbXfer(1'b0, 16'h001C, 32'h0, 1'b0, rd, err);
        check("unmapped err", 64'(err[0]), 64'd1);
        check("unmapped rdata", 64'(rd[0]), 64'd0);
        apbXfer(1'b1, 16'h0040, 32'hFFFF_FFFF, 1'b0, rd, err);
        check("unmapped wr err", 64'(err[0]), 64'd1);
        for (int a = 0; a < 6; a++) begin
            addr = (a < 3) ? 16'(a * 4) : 16'(16 + (a - 3) * 4);
            apbXfer(1'b0, addr, 32'h0, 1'b0, rd, err);
        end
        apbXfer(1'b1, 16'h0000, 32'h6, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0010, 32'h0, 1'b0, rd, err);
        check("clear zeroes shadow", 64'(rd[0]), 64'd0);
        check("clear keeps committed", 64'(valFlat[0][19:0]), 64'd98);
        ackCycle();

        // Randomized traffic.
        repeat (160) begin
            if ($urandom_range(0, 9) == 0) begin
                ackCycle();
            end else begin
                addr = addrs[$urandom_range(0, 10)];
                if (addr[7:0] == 8'h00 || addr[7:0] == 8'h04) data = 32'($urandom_range(0, 7));
                else if ($urandom_range(0, 3) == 0)            data = $urandom;
                else                                           data = 32'($urandom_range(0, 1200));
                apbXfer($urandom_range(0, 2) != 0, addr, data, $urandom_range(0, 3) == 0, rd, err);
            end
        end

        // Commit counter wrap: back-to-back access cycles, one commit each.
        pulseReset();
        @(posedge periCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h2;
        @(posedge periCLK); #1;
        penable = 1'b1;
        repeat (65535) begin
            @(posedge periCLK);
            for (int i = 0; i < 2; i++) modelStep(i, 1'b1, 1'b1, 16'h0000, 32'h2, 1'b0, dRd, dErr);
        end
        #1 psel = 1'b0; penable = 1'b0;
        checkOutputs("burst");
        apbXfer(1'b0, 16'h0008, 32'h0, 1'b0, rd, err);
        check("cnt preload", 64'(rd[0]), 64'hFFFF);
        apbXfer(1'b1, 16'h0000, 32'h2, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0008, 32'h0, 1'b0, rd, err);
        check("cnt wrap", 64'(rd[0]), 64'h0);

        // Reset in the middle of an access cycle.
        apbXfer(1'b1, 16'h0010, 32'h55, 1'b0, rd, err);
        apbXfer(1'b1, 16'h0000, 32'h3, 1'b0, rd, err);
        @(posedge periCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
        @(posedge periCLK); #1;
        penable = 1'b1;
        #2 asyncReset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("midreset val_flat[%0d]", i), 64'(valFlat[i]), 64'd0);
            check($sformatf("midreset val_stb[%0d]", i), 64'(valStb[i]), 64'd0);
            check($sformatf("midreset prdata[%0d]", i), 64'(prdata[i]), 64'd0);
            check($sformatf("midreset pslverr[%0d]", i), 64'(pslverr[i]), 64'd0);
        end
        @(negedge periCLK);
        psel = 1'b0; penable = 1'b0;
        @(posedge periCLK); #1;
        asyncReset = 1'b0;
        modelReset();
        apbXfer(1'b0, 16'h0008, 32'h0, 1'b0, rd, err);
        check("post reset cnt", 64'(rd[0]), 64'd0);
        apbXfer(1'b0, 16'h0000, 32'h0, 1'b0, rd, err);
        check("post reset auto", 64'(rd[0]), 64'd0);
        apbXfer(1'b1, 16'h0010, 32'd321, 1'b0, rd, err);
        apbXfer(1'b0, 16'h0010, 32'h0, 1'b0, rd, err);
        check("post reset write", 64'(rd[0]), 64'd321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
